// File: rtl/trig_capture_ctrl.sv
// Trigger-qualified capture controller: streams registered ADC samples into a
// circular sample RAM and freezes it once the post-trigger window is full.
module trig_capture_ctrl #(
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 10000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        sample_in,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [7:0]        trig_level,
  input  logic              trig_slope,
  input  logic [ADDR_W-1:0] pre_len,
  output logic [7:0]        write_data_out,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic              cs,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr
);

  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [7:0]        prev;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] pre_lat;

  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] count_inc;
  logic [ADDR_W-1:0] post_len;
  logic [ADDR_W-1:0] pre_clamp;
  logic [ADDR_W-1:0] start_calc;
  logic              pre_full;
  logic              post_full;
  logic              trig_hit;

  // NOTE: every always_comb output gets a value on every path, so no latches form.
  always_comb begin
    addr_inc   = (address == LAST) ? '0 : address + 1'b1;
    count_inc  = count + 1'b1;
    post_len   = LAST - pre_lat;
    pre_clamp  = (pre_len >= ADDR_W'(DEPTH)) ? LAST : pre_len;
    pre_full   = (count_inc >= pre_lat);
    post_full  = (count_inc >= post_len);
    // Wrap-safe (address - pre_lat) mod DEPTH without relying on 2^N truncation.
    start_calc = (address >= pre_lat) ? address - pre_lat
                                      : LAST - (pre_lat - address) + 1'b1;
    trig_hit   = force_trig;
    if (trig_slope) begin
      if (prev < trig_level && write_data_out >= trig_level) trig_hit = 1'b1;
    end else begin
      if (prev > trig_level && write_data_out <= trig_level) trig_hit = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of all the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      write_data_out <= '0;
      address        <= '0;
      write          <= 1'b0;
      cs             <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      trig_addr      <= '0;
      start_addr     <= '0;
      prev           <= '0;
      count          <= '0;
      pre_lat        <= '0;
    end else begin
      write_data_out <= sample_in;
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            state   <= PRE;
            address <= '0;
            done    <= 1'b0;
            busy    <= 1'b1;
            write   <= 1'b1;
            cs      <= 1'b1;
            pre_lat <= pre_clamp;
            count   <= '0;
          end
        end
        PRE: begin
          prev    <= write_data_out;
          address <= addr_inc;
          count   <= count_inc;
          if (pre_full) state <= WAIT;
        end
        WAIT: begin
          prev <= write_data_out;
          if (trig_hit) begin
            trig_addr  <= address;
            start_addr <= start_calc;
            count      <= '0;
            if (post_len == '0) begin
              // Full pre-trigger window: the trigger sample is the last write.
              state <= DONE;
              busy  <= 1'b0;
              write <= 1'b0;
              cs    <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= POST;
              address <= addr_inc;
            end
          end else begin
            address <= addr_inc;
          end
        end
        POST: begin
          prev  <= write_data_out;
          count <= count_inc;
          if (post_full) begin
            state <= DONE;
            busy  <= 1'b0;
            write <= 1'b0;
            cs    <= 1'b0;
            done  <= 1'b1;
          end else begin
            address <= addr_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Self-checking bench for trig_capture_ctrl: a sample-stream model predicts
// which write triggers, where the buffer ends and what the frozen RAM holds.
module tb_trig_capture_ctrl;

  localparam int ADDR_W = 17;
  localparam int DEPTH  = 16;
  localparam int BUDGET = 300;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        sample_in = '0;
  logic              arm = 1'b0;
  logic              force_trig = 1'b0;
  logic [7:0]        trig_level = '0;
  logic              trig_slope = 1'b0;
  logic [ADDR_W-1:0] pre_len = '0;
  logic [7:0]        write_data_out;
  logic [ADDR_W-1:0] address;
  logic              write;
  logic              cs;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;

  int checks = 0;
  int failures = 0;

  logic [7:0] ram [DEPTH];

  trig_capture_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .arm(arm),
    .force_trig(force_trig), .trig_level(trig_level), .trig_slope(trig_slope),
    .pre_len(pre_len), .write_data_out(write_data_out), .address(address),
    .write(write), .cs(cs), .busy(busy), .done(done), .trig_addr(trig_addr),
    .start_addr(start_addr)
  );

  always #5 clk = ~clk;

  // Behavioural sample RAM fed by the DUT's write port.
  always @(posedge clk)
    if (write && int'(address) < DEPTH) ram[int'(address)] <= write_data_out;

  function automatic logic [7:0] gen(input int mode, input int t);
    case (mode)
      0: return 8'((t * 16) % 256);
      1: return (t < 40) ? 8'hFF : 8'h20;
      2: return 8'h55;
      4: return (t < 25) ? 8'h80 : ((t == 25) ? 8'h10 : 8'h90);
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  function automatic bit fires(input int slope, input int lvl, input int p, input int c);
    if (slope != 0) return (p < lvl) && (c >= lvl);
    return (p > lvl) && (c <= lvl);
  endfunction

  // Runs one capture: sample t of the stream is written as write t at address t mod DEPTH.
  // force_slot / arm_slot / reset_slot name the drive slot (slot t lands on edge t).
  task automatic run_capture(input string name, input int pre, input int lvl,
                             input int slope, input int mode, input int force_slot,
                             input int arm_slot, input int reset_slot);
    int pre_eff, first_wait, trig_idx, total, exp_start, j;
    bit f;
    logic [7:0] samp [$];
    logic [ADDR_W+11:0] got, exp;
    pre_eff    = (pre >= DEPTH) ? DEPTH - 1 : pre;
    first_wait = (pre_eff == 0) ? 1 : pre_eff;
    trig_idx   = -1;
    total      = -1;
    @(negedge clk);
    arm = 1'b1; force_trig = 1'b0; trig_level = 8'(lvl); trig_slope = slope[0];
    pre_len = ADDR_W'(pre); sample_in = gen(mode, 0);
    samp.push_back(sample_in);
    @(negedge clk);
    for (int t = 1; t < BUDGET; t++) begin
      got = {write, cs, busy, done, address, write_data_out};
      exp = {1'b1, 1'b1, 1'b1, 1'b0, ADDR_W'((t - 1) % DEPTH), samp[t-1]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s write%0d: got w/cs/busy/done/addr/data=%h expected %h", name, t - 1, got, exp);
      end
      if (t == reset_slot) begin
        reset_n = 1'b0; arm = 1'b0; force_trig = 1'b0;
        #1;
        checks++;
        if ({write, cs, busy, done, address, write_data_out, trig_addr, start_addr} !== '0) begin
          failures++;
          $display("FAIL %s async_reset: got w=%b cs=%b busy=%b done=%b addr=%0d data=%h trig=%0d start=%0d expected all 0",
                   name, write, cs, busy, done, address, write_data_out, trig_addr, start_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({write, cs, busy, done, address} !== '0) begin
          failures++;
          $display("FAIL %s idle_after_reset: got w=%b cs=%b busy=%b done=%b addr=%0d expected all 0",
                   name, write, cs, busy, done, address);
        end
        return;
      end
      arm        = (t == arm_slot);
      f          = (t == force_slot);
      force_trig = f;
      sample_in  = gen(mode, t);
      samp.push_back(sample_in);
      j = t - 1;
      if (trig_idx < 0 && j >= first_wait &&
          (f || fires(slope, lvl, int'(samp[j-1]), int'(samp[j])))) begin
        trig_idx = j;
        total    = j + 1 + (DEPTH - 1 - pre_eff);
      end
      @(negedge clk);
      if (total >= 0 && t == total) break;
    end
    arm = 1'b0; force_trig = 1'b0;
    checks++;
    if (total < 0) begin
      failures++;
      $display("FAIL %s budget: no trigger within %0d slots, expected one", name, BUDGET);
      return;
    end
    exp_start = ((trig_idx - pre_eff) % DEPTH + DEPTH) % DEPTH;
    got = {write, cs, busy, done, address, 8'h00};
    exp = {1'b0, 1'b0, 1'b0, 1'b1, ADDR_W'((total - 1) % DEPTH), 8'h00};
    if (got !== exp) begin
      failures++;
      $display("FAIL %s done_state: got w/cs/busy/done/addr=%h expected %h", name, got, exp);
    end
    checks++;
    if (trig_addr !== ADDR_W'(trig_idx % DEPTH) || start_addr !== ADDR_W'(exp_start)) begin
      failures++;
      $display("FAIL %s addrs: got trig=%0d start=%0d expected trig=%0d start=%0d",
               name, trig_addr, start_addr, trig_idx % DEPTH, exp_start);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (write !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL %s frozen: got write=%b done=%b expected write=0 done=1", name, write, done);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ram[(exp_start + i) % DEPTH] !== samp[total - DEPTH + i]) begin
        failures++;
        $display("FAIL %s ram[%0d]: got %h expected %h", name, (exp_start + i) % DEPTH,
                 ram[(exp_start + i) % DEPTH], samp[total - DEPTH + i]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({write, cs, busy, done, address, write_data_out, trig_addr, start_addr} !== '0) begin
      failures++;
      $display("FAIL reset: got w=%b cs=%b busy=%b done=%b addr=%0d data=%h expected all 0",
               write, cs, busy, done, address, write_data_out);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (write !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_arm: got write=%b busy=%b expected 0 0", write, busy);
    end
  endtask

  task automatic test_rising();
    run_capture("rising", 4, 8'h80, 1, 0, -1, -1, -1);
    checks++;
    if (trig_addr !== 8 || start_addr !== 4) begin
      failures++;
      $display("FAIL rising_const: got trig=%0d start=%0d expected 8 4", trig_addr, start_addr);
    end
  endtask

  task automatic test_falling_wrap();
    run_capture("falling", 15, 8'h40, 0, 1, -1, -1, -1);
    checks++;
    if (trig_addr !== 8 || start_addr !== 9) begin
      failures++;
      $display("FAIL falling_const: got trig=%0d start=%0d expected 8 9", trig_addr, start_addr);
    end
  endtask

  task automatic test_force();
    run_capture("force", 0, 8'h55, 1, 2, 5, -1, -1);
    checks++;
    if (trig_addr !== 4 || start_addr !== 4) begin
      failures++;
      $display("FAIL force_const: got trig=%0d start=%0d expected 4 4", trig_addr, start_addr);
    end
  endtask

  task automatic test_clamp_ignored_arm();
    run_capture("clamp", 20, 8'h80, 1, 4, -1, 18, -1);
    checks++;
    if (trig_addr !== 10 || start_addr !== 11) begin
      failures++;
      $display("FAIL clamp_const: got trig=%0d start=%0d expected 10 11", trig_addr, start_addr);
    end
  endtask

  task automatic test_reset_mid_post();
    run_capture("reset_post", 4, 8'h80, 1, 0, -1, -1, 12);
    run_capture("after_reset", 4, 8'h80, 1, 0, -1, -1, -1);
  endtask

  task automatic test_back_to_back();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL rearm_pre: got done=%b expected 1", done);
    end
    run_capture("rearm", 2, 8'hC0, 0, 0, 9, -1, -1);
  endtask

  task automatic test_random();
    int pre, fw;
    for (int n = 0; n < 8; n++) begin
      pre = $urandom_range(0, 20);
      fw  = (pre >= DEPTH) ? DEPTH - 1 : ((pre == 0) ? 1 : pre);
      run_capture("random", pre, $urandom_range(0, 255), $urandom_range(0, 1), 3,
                  fw + 1 + $urandom_range(0, 30),
                  ($urandom_range(0, 1) != 0) ? fw + 1 : -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_rising();
    test_falling_wrap();
    test_force();
    test_clamp_ignored_arm();
    test_reset_mid_post();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
